// File: rtl/multisim_quasi_static_arbiter.sv
// Round-robin push arbiter for quasi-static sources: each source is re-sent only when its
// value differs from the copy last captured for it; intermediate changes are coalesced.

module msqa_src_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] src_i,
  input  logic                  cap_i,
  output logic                  pend_o,
  output logic                  chg_o
);
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  pend_q, pend_d;

  // Compare against the post-capture shadow so a captured lane clears in the same edge.
  assign shadow_d = cap_i ? src_i : shadow_q;
  assign pend_d   = (src_i != shadow_d);
  assign chg_o    = pend_q && !cap_i && (src_i != prev_q);
  assign pend_o   = pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      prev_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      prev_q   <= src_i;
      pend_q   <= pend_d;
    end
  end
endmodule

module multisim_quasi_static_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [IDX_W-1:0]              out_idx_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [NUM_SRC-1:0]            pending_o,
  output logic [15:0]                   coalesce_cnt_o
);
  typedef enum logic {IDLE, SEND} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   last_q, last_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]              data_q, data_d;
  logic [15:0]                        cnt_q, cnt_d;

  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_w;
  logic [NUM_SRC-1:0]                 pend, chg, cap;
  logic [IDX_W-1:0]                   gnt_idx;
  logic                               gnt_found;

  assign src_w = src_data_i;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    msqa_src_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .src_i  (src_w[i]),
      .cap_i  (cap[i]),
      .pend_o (pend[i]),
      .chg_o  (chg[i])
    );
  end

  // Search starts one past the last granted source and wraps.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = (int'(last_q) + k) % NUM_SRC;
      if (!gnt_found && pend[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cap     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          cap[gnt_idx] = 1'b1;
          idx_d        = gnt_idx;
          data_d       = src_w[gnt_idx];
          state_d      = SEND;
        end
      end
      SEND: begin
        if (out_ready_i) begin
          last_d  = idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_d = ((|chg) && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_SRC - 1);
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o    = (state_q == SEND);
  assign out_idx_o      = idx_q;
  assign out_data_o     = data_q;
  assign pending_o      = pend;
  assign coalesce_cnt_o = cnt_q;
endmodule

// File: tb/tb_multisim_quasi_static_arbiter.sv
// Directed bench for multisim_quasi_static_arbiter (NUM_SRC=4, DATA_WIDTH=32).

module tb_multisim_quasi_static_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_idx;
  logic [31:0]  out_data;
  logic [3:0]   pending;
  logic [15:0]  ccnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multisim_quasi_static_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .src_data_i     (src),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_idx_o      (out_idx),
    .out_data_o     (out_data),
    .pending_o      (pending),
    .coalesce_cnt_o (ccnt)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src       = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({out_valid, out_idx, out_data, pending, ccnt} !== 55'd0) begin
      nerr++;
      $display("FAIL reset_state: got v=%b idx=%0d data=%h pend=%b cnt=%0d, want all zero",
               out_valid, out_idx, out_data, pending, ccnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    set_src(2, 32'h0000_00A5);
    tick();
    nvec++;
    if (pending !== 4'b0100 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL single_pending: got pend=%b v=%b, want 0100 0", pending, out_valid);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2 || out_data !== 32'hA5) begin
      nerr++;
      $display("FAIL single_word: got v=%b idx=%0d data=%h, want 1 2 000000a5", out_valid, out_idx, out_data);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0 || pending !== 4'b0000) begin
        nerr++;
        $display("FAIL single_after t=%0d: got v=%b pend=%b, want 0 0000", t, out_valid, pending);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    int   k;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 32'h10 + i);
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_v = (t >= 2) && (t <= 8) && (t % 2 == 0);
      k     = (t - 2) / 2;
      nvec++;
      if (out_valid !== exp_v) begin
        nerr++;
        $display("FAIL b2b_valid t=%0d: got %b want %b", t, out_valid, exp_v);
      end else if (exp_v && (out_idx !== 2'(k) || out_data !== 32'h10 + k)) begin
        nerr++;
        $display("FAIL b2b_word t=%0d: got idx=%0d data=%h want idx=%0d data=%h",
                 t, out_idx, out_data, k, 32'h10 + k);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_src(1, 32'h11);
    tick();
    tick();
    for (int t = 0; t < 10; t++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'h11) begin
        nerr++;
        $display("FAIL stall_hold t=%0d: got v=%b idx=%0d data=%h want 1 1 00000011", t, out_valid, out_idx, out_data);
      end
      if (t == 4) set_src(1, 32'h22);
      tick();
    end
    nvec++;
    if (pending !== 4'b0010) begin
      nerr++;
      $display("FAIL stall_repend: got pend=%b want 0010", pending);
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stall_gap: got v=%b want 0", out_valid);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'h22) begin
      nerr++;
      $display("FAIL stall_resend: got v=%b idx=%0d data=%h want 1 1 00000022", out_valid, out_idx, out_data);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) begin
      nerr++;
      $display("FAIL stall_done: got v=%b pend=%b want 0 0000", out_valid, pending);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    set_src(0, 32'h1);
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || ccnt !== 16'd0) begin
      nerr++;
      $display("FAIL coal_hold: got v=%b idx=%0d cnt=%0d want 1 0 0", out_valid, out_idx, ccnt);
    end
    set_src(3, 32'h1);
    tick();
    set_src(3, 32'h2);
    tick();
    set_src(3, 32'h3);
    tick();
    nvec++;
    if (ccnt !== 16'd2 || pending !== 4'b1000) begin
      nerr++;
      $display("FAIL coal_count: got cnt=%0d pend=%b want 2 1000", ccnt, pending);
    end
    out_ready = 1'b1;
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd3 || out_data !== 32'h3) begin
      nerr++;
      $display("FAIL coal_word: got v=%b idx=%0d data=%h want 1 3 00000003", out_valid, out_idx, out_data);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0 || ccnt !== 16'd2) begin
        nerr++;
        $display("FAIL coal_single t=%0d: got v=%b cnt=%0d want 0 2", t, out_valid, ccnt);
      end
    end
  endtask

  task automatic test_return();
    do_reset();
    set_src(0, 32'h9);
    tick();
    tick();
    set_src(1, 32'h5);
    tick();
    nvec++;
    if (pending[1] !== 1'b1 || out_idx !== 2'd0 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL ret_set: got pend=%b v=%b idx=%0d want pend[1]=1 v=1 idx=0", pending, out_valid, out_idx);
    end
    set_src(1, 32'h0);
    tick();
    nvec++;
    if (pending !== 4'b0000) begin
      nerr++;
      $display("FAIL ret_clear: got pend=%b want 0000", pending);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL ret_noword t=%0d: got v=%b idx=%0d want v=0", t, out_valid, out_idx);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    set_src(2, 32'h7);
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      nerr++;
      $display("FAIL rms_pre: got v=%b idx=%0d want 1 2", out_valid, out_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, out_idx, out_data, pending, ccnt} !== 55'd0) begin
      nerr++;
      $display("FAIL rms_async: got v=%b idx=%0d data=%h pend=%b cnt=%0d want all zero",
               out_valid, out_idx, out_data, pending, ccnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    nvec++;
    if (pending !== 4'b0100 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rms_repend: got pend=%b v=%b want 0100 0", pending, out_valid);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2 || out_data !== 32'h7 || ccnt !== 16'd0) begin
      nerr++;
      $display("FAIL rms_resend: got v=%b idx=%0d data=%h cnt=%0d want 1 2 00000007 0",
               out_valid, out_idx, out_data, ccnt);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    src       = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_coalesce();
    test_return();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
